// File: rtl/seven_seg_scanner_pkg.sv
// rtl/seven_seg_scanner_pkg.sv - segment glyphs, digit slots and defaults for the scanner
// Glyphs are active-low {g,f,e,d,c,b,a}; a cleared bit lights that segment.
package seven_seg_scanner_pkg;

  localparam int REFRESH_DIV_DEFAULT = 100000;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef enum logic [1:0] {
    DIG_UNITS    = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_HUNDREDS = 2'd2,
    DIG_SPARE    = 2'd3
  } digit_e;

  function automatic logic [3:0] anode_for(digit_e d);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << d;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_bcd_to_seg.sv
// rtl/seven_seg_scanner_bcd_to_seg.sv - combinational nibble to active-low segment decode
// Non-BCD nibbles (10..15) render as a dash so upstream conversion faults stay visible.
module bcd_to_seg
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - three-digit multiplexed seven-segment scanner with leading-zero blanking
// Held BCD value is scanned units, tens, hundreds, spare; an/seg are registered one cycle behind.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT,
  parameter int BLANK_LZ    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] bcd,
  input  logic        bcd_valid,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int              CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic            LZ_ON   = (BLANK_LZ != 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_e           idx_q, idx_d;
  logic [11:0]      held_q, held_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic             tick;
  logic [3:0]       nib;
  logic [6:0]       nib_seg;
  logic             blank;
  logic             hund_zero;
  logic             tens_zero;

  always_comb begin
    tick   = (cnt_q == CNT_MAX);
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = tick ? digit_e'(idx_q + 2'd1) : idx_q;
    held_d = bcd_valid ? bcd : held_q;
  end

  // A dash nibble is non-zero here, so it keeps lower digits from blanking.
  always_comb begin
    hund_zero = (held_q[11:8] == 4'd0);
    tens_zero = (held_q[7:4] == 4'd0);
    nib       = 4'd0;
    blank     = 1'b0;
    case (idx_q)
      DIG_UNITS: begin
        nib = held_q[3:0];
      end
      DIG_TENS: begin
        nib   = held_q[7:4];
        blank = LZ_ON && hund_zero && tens_zero;
      end
      DIG_HUNDREDS: begin
        nib   = held_q[11:8];
        blank = LZ_ON && hund_zero;
      end
      default: begin
        blank = 1'b1;
      end
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .nibble (nib),
    .seg    (nib_seg)
  );

  always_comb begin
    an_d  = anode_for(idx_q);
    seg_d = blank ? SEG_BLANK : nib_seg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= DIG_UNITS;
      held_q <= 12'h000;
      an_q   <= AN_OFF;
      seg_q  <= SEG_BLANK;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      held_q <= held_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - scoreboard bench for seven_seg_scanner, blanking on and off
`timescale 1ns/1ps
module tb_seven_seg_scanner;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] bcd = 12'h000;
  logic        bcd_valid = 1'b0;

  logic [3:0]  an_lz, an_all;
  logic [6:0]  seg_lz, seg_all;
  logic        dp_lz, dp_all;

  seven_seg_scanner #(.REFRESH_DIV(DIV), .BLANK_LZ(1)) dut_lz (
    .clk       (clk),
    .reset     (reset),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .an        (an_lz),
    .seg       (seg_lz),
    .dp        (dp_lz)
  );

  seven_seg_scanner #(.REFRESH_DIV(DIV), .BLANK_LZ(0)) dut_all (
    .clk       (clk),
    .reset     (reset),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .an        (an_all),
    .seg       (seg_all),
    .dp        (dp_all)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg_lz;
    logic [6:0] seg_all;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          edge_n = 0;
  logic [11:0] held_m = 12'h000;

  function automatic logic [6:0] glyph(logic [3:0] n);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (n > 4'd9) return 7'h3F;
    return tbl[n];
  endfunction

  function automatic logic [6:0] slot_seg(logic [11:0] v, int slot, bit blz);
    logic [3:0] h, t, u;
    h = v[11:8];
    t = v[7:4];
    u = v[3:0];
    if (slot == 3) return 7'h7F;
    if (slot == 2) return (blz && h == 0) ? 7'h7F : glyph(h);
    if (slot == 1) return (blz && h == 0 && t == 0) ? 7'h7F : glyph(t);
    return glyph(u);
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: edge e after release shows slot ((e-1)/DIV)%4 of the value held before e.
  always @(posedge clk or posedge reset) begin : model
    exp_t x;
    int   slot;
    if (reset) begin
      edge_n = 0;
      held_m = 12'h000;
      exp_q.delete();
    end else begin
      edge_n++;
      slot = ((edge_n - 1) / DIV) % 4;
      x.an = 4'hF;
      x.an[slot] = 1'b0;
      x.seg_lz  = slot_seg(held_m, slot, 1'b1);
      x.seg_all = slot_seg(held_m, slot, 1'b0);
      exp_q.push_back(x);
      if (bcd_valid) held_m = bcd;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t x;
    if (reset || exp_q.size() == 0) begin
      x.an = 4'hF;
      x.seg_lz = 7'h7F;
      x.seg_all = 7'h7F;
    end else begin
      x = exp_q.pop_front();
    end
    check("an_lz",   {4'h0, an_lz},   {4'h0, x.an});
    check("an_all",  {4'h0, an_all},  {4'h0, x.an});
    check("seg_lz",  {1'b0, seg_lz},  {1'b0, x.seg_lz});
    check("seg_all", {1'b0, seg_all}, {1'b0, x.seg_all});
    check("dp",      {6'h0, dp_lz, dp_all}, 8'h03);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic strobe(logic [11:0] v);
    bcd = v;
    bcd_valid = 1'b1;
    cyc();
    bcd_valid = 1'b0;
  endtask

  function automatic logic [3:0] rnd_nib();
    return ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
  endfunction

  initial begin
    int guard;
    run(3);
    reset = 1'b0;
    run(20);

    strobe(12'h255);
    run(18);
    bcd = 12'h999;
    run(18);
    strobe(12'h007);
    run(18);
    strobe(12'h10A);
    run(18);
    strobe(12'h0A0);
    run(18);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < DIV && ((edge_n + 1) % DIV) != 0; i++) cyc();
      strobe({rnd_nib(), rnd_nib(), rnd_nib()});
      run($urandom_range(1, 9));
    end

    bcd_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bcd = {rnd_nib(), rnd_nib(), rnd_nib()};
      cyc();
    end
    bcd_valid = 1'b0;

    for (int i = 0; i < 300; i++) begin
      bcd = {rnd_nib(), rnd_nib(), rnd_nib()};
      bcd_valid = ($urandom_range(0, 3) == 0);
      cyc();
    end
    bcd_valid = 1'b0;

    strobe(12'h255);
    guard = 0;
    while (!(((edge_n / DIV) % 4) == 2 && (edge_n % DIV) == 1) && guard < 4 * DIV + 2) begin
      cyc();
      guard++;
    end
    if (guard >= 4 * DIV + 2) begin
      vectors++;
      miscompares++;
      $display("FAIL slot2_wait got timeout want index 2");
    end
    reset = 1'b1;
    #1;
    check("async_an_lz",   {4'h0, an_lz},   8'h0F);
    check("async_seg_lz",  {1'b0, seg_lz},  8'h7F);
    check("async_an_all",  {4'h0, an_all},  8'h0F);
    check("async_seg_all", {1'b0, seg_all}, 8'h7F);
    #1;
    run(3);
    reset = 1'b0;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range 2..2^20.
REQ-002 Parameter BLANK_LZ, default 1, 1 = leading-zero blanking enabled, 0 = all three digits always shown.
REQ-003 Port clk  input  1  single system clock, all state on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port bcd  input  12  packed BCD value {hundreds[11:8], tens[7:4], units[3:0]} from the binary-to-BCD stage.
REQ-006 Port bcd_valid  input  1  capture strobe; bcd is sampled on any rising edge where it is high.
REQ-007 Port an  output  4  digit anodes, active-low, an[0] = units (rightmost).
REQ-008 Port seg  output  7  cathodes, active-low, seg[0]=a ... seg[6]=g.
REQ-009 Port dp  output  1  decimal point, active-low, constant 1 (off) outside reset and after reset.

Function
REQ-010 A held register SHALL load bcd on each edge with bcd_valid=1 and otherwise keep its value; the display uses only the held value.
REQ-011 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick is asserted for the one cycle in which the count equals REFRESH_DIV-1.
REQ-012 A 2-bit digit index SHALL advance 0->1->2->3->0 on each tick and hold otherwise.
REQ-013 an and seg SHALL be registered and reflect the index and held value of the previous cycle (1-cycle output latency).
REQ-014 an SHALL have exactly one bit low, bit = index, at all times after the first post-reset cycle.
REQ-015 Index 0 SHALL show units; index 1 tens; index 2 hundreds; index 3 SHALL always be blank (seg=7'h7F).
REQ-016 Nibble decode, seg as hex {g..a}: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10; nibbles 10..15 SHALL show dash (3F).
REQ-017 With BLANK_LZ=1: hundreds blank if it equals 0; tens blank if hundreds and tens both equal 0; units are never blanked.
REQ-018 A dash (invalid nibble) SHALL count as non-zero for blanking purposes.
REQ-019 bcd_valid coincident with tick: both SHALL take effect; the new held value is used from the next cycle onward.
REQ-020 bcd_valid held high continuously SHALL track bcd each cycle, with total bcd-to-seg latency of 2 cycles.
REQ-021 Prescaler and index wrap SHALL be free-running and independent of bcd_valid.

Reset
REQ-022 While reset=1: prescaler=0, index=0, held=12'h000, an=4'hF, seg=7'h7F, dp=1.
REQ-023 On the first edge after reset release, an=4'hE and seg=7'h40 (units "0").
REQ-024 Reset asserted mid-scan SHALL force the REQ-022 values immediately, without waiting for a clock edge, and discard the held value.

Structure
REQ-025 A shared package SHALL hold the segment constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK) and the REFRESH_DIV default.
REQ-026 The nibble-to-segment decode SHALL be a combinational sub-module bcd_to_seg (4-bit in, 7-bit active-low out) that uses the package constants.
REQ-027 The prescaler, index, held register, blanking logic and output registers SHALL be in the top level.

Verification (REFRESH_DIV=4 for simulation)
REQ-028 Reset, then release with no strobe -> an cycles E,D,B,7 every 4 clocks; seg 40 in the units slot and 7F in all other slots.
REQ-029 bcd=12'h255 with one-cycle bcd_valid -> units 12, tens 12, hundreds 24, slot 3 7F; the value persists after bcd changes with bcd_valid=0.
REQ-030 bcd=12'h007, BLANK_LZ=1 -> hundreds 7F, tens 7F, units 78; with BLANK_LZ=0 -> hundreds 40, tens 40, units 78.
REQ-031 bcd=12'h10A -> units 3F, tens 40 (not blanked, because hundreds is non-zero), hundreds 79; bcd=12'h0A0 -> tens 3F, hundreds 7F.
REQ-032 bcd_valid pulsed in the same cycle as tick -> the next slot shows the new value 2 cycles after the strobe; an stays one-hot throughout.
REQ-033 reset asserted mid-slot at index 2 -> an=F and seg=7F immediately; after release the scan restarts at index 0 showing "0".
